// File: rtl/rr_mux_n.sv
// N-channel registered arbitrating multiplexer with valid/ready handshakes.
// Runs in external-select or round-robin mode and has a single backpressured output register.
module rr_mux_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      rr_en,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_q,      last_d;

    logic             grant;
    logic [SEL_W-1:0] gidx;
    logic [WIDTH-1:0] gdata;
    logic             load;
    logic             xfer;

    // Round-robin walks offsets from CHANNELS down to 1 so the smallest
    // offset after last (highest priority) is the final assignment that wins.
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        gdata = '0;
        if (!rr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant = 1'b1;
                    gidx  = SEL_W'(i);
                    gdata = in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (i == (int'(last_q) + k) % CHANNELS && in_valid[i]) begin
                        grant = 1'b1;
                        gidx  = SEL_W'(i);
                        gdata = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = load && grant;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !rst && xfer && (gidx == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = gdata;
            out_chan_d  = gidx;
            out_valid_d = 1'b1;
            last_d      = gidx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n: 8-channel main instance plus a 6-channel
// instance for out-of-range select. Expected output words go through a queue.
module tb_rr_mux_n;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int N6 = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [2:0]     sel;
    logic           rr_en;
    logic [W-1:0]   out_data;
    logic [2:0]     out_chan;
    logic           out_valid;
    logic           out_ready;

    logic [N6*W-1:0] in_data6;
    logic [N6-1:0]   in_valid6;
    logic [N6-1:0]   in_ready6;
    logic [2:0]      sel6;
    logic [W-1:0]    out_data6;
    logic [2:0]      out_chan6;
    logic            out_valid6;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_mux_n #(.WIDTH(W), .CHANNELS(N), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_n #(.WIDTH(W), .CHANNELS(N6), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .sel(sel6), .rr_en(1'b0), .out_data(out_data6),
        .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(1'b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
        in_valid  = '1;
        in_valid6 = '1;
        rr_en     = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({in_ready, out_valid, out_data, out_chan} !== {8'h00, 1'b0, 16'h0000, 3'd0}) begin
                errors++;
                $display("FAIL reset_cyc%0d: ready=%b valid=%b data=%h chan=%0d, want 0/0/0000/0",
                         c, in_ready, out_valid, out_data, out_chan);
            end
            checks++;
            if (in_ready6 !== 6'b0) begin
                errors++;
                $display("FAIL reset_ready6: got %b want 000000", in_ready6);
            end
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b want 00000001", in_ready);
        end
        sb.push_back('{d: 16'h1000, c: 3'd0});
        step();
        in_valid  = '0;
        in_valid6 = '0;
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL reset_first_out: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        step();
    endtask

    task automatic test_ext_select();
        rr_en = 1'b0;
        sel   = 3'd5;
        in_data[5*W +: W] = 16'hA5A5;
        in_data[2*W +: W] = 16'h2222;
        in_valid  = 8'b0010_0100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'b0010_0000) begin
            errors++;
            $display("FAIL sel_ready: got %b want 00100000", in_ready);
        end
        sb.push_back('{d: 16'hA5A5, c: 3'd5});
        step();
        in_valid = 8'b0000_0100;
        #1;
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL sel_out: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        checks++;
        if (in_ready !== 8'b0) begin
            errors++;
            $display("FAIL sel_ignore_ch2: ready=%b want 00000000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_drain: valid=%b want 0", out_valid);
        end
        in_valid = '0;
    endtask

    task automatic test_rr_fairness();
        pulse_reset();
        rr_en = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (in_ready !== 8'(1 << (k % N))) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b want chan %0d", k, in_ready, k % N);
            end
            sb.push_back('{d: 16'h1000 + 16'(k % N), c: 3'(k % N)});
            step();
            e = sb.pop_front();
            checks++;
            if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
                errors++;
                $display("FAIL rr_out_%0d: v=%b chan=%0d data=%h want chan=%0d data=%h",
                         k, out_valid, out_chan, out_data, e.c, e.d);
            end
        end
        in_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        rr_en    = 1'b0;
        sel      = 3'd3;
        in_valid = 8'b0000_1000;
        step();
        out_ready = 1'b0;
        rr_en     = 1'b1;
        in_valid  = '1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, out_chan, out_data} !== {8'h00, 1'b1, 3'd3, 16'h1003}) begin
                errors++;
                $display("FAIL bp_hold_%0d: ready=%b v=%b chan=%0d data=%h want 0/1/3/1003",
                         c, in_ready, out_valid, out_chan, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'b0001_0000) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 00010000", in_ready);
        end
        sb.push_back('{d: 16'h1004, c: 3'd4});
        step();
        in_valid = '0;
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL bp_next_word: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        step();
    endtask

    task automatic test_sparse_wrap();
        rr_en    = 1'b0;
        sel      = 3'd6;
        in_valid = 8'b0100_0000;
        step();
        rr_en    = 1'b1;
        in_valid = 8'b1000_0010;
        #1;
        checks++;
        if (in_ready !== 8'b1000_0000) begin
            errors++;
            $display("FAIL wrap_ready_ch7: got %b want 10000000", in_ready);
        end
        sb.push_back('{d: 16'h1007, c: 3'd7});
        step();
        in_valid = 8'b0000_0010;
        #1;
        checks++;
        if (in_ready !== 8'b0000_0010) begin
            errors++;
            $display("FAIL wrap_ready_ch1: got %b want 00000010", in_ready);
        end
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL wrap_out_ch7: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        sb.push_back('{d: 16'h1001, c: 3'd1});
        step();
        in_valid = '0;
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL wrap_out_ch1: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        step();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b0, 3'd1, 16'h1001}) begin
            errors++;
            $display("FAIL wrap_drain: v=%b chan=%0d data=%h want 0/1/1001",
                     out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_mode_switch();
        rr_en    = 1'b0;
        sel      = 3'd3;
        in_valid = 8'b0000_1000;
        step();
        rr_en    = 1'b1;
        in_valid = 8'b0001_0100;
        #1;
        checks++;
        if (in_ready !== 8'b0001_0000) begin
            errors++;
            $display("FAIL mode_ready: got %b want 00010000", in_ready);
        end
        sb.push_back('{d: 16'h1004, c: 3'd4});
        step();
        in_valid = '0;
        e = sb.pop_front();
        checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, e.c, e.d}) begin
            errors++;
            $display("FAIL mode_out: v=%b chan=%0d data=%h want chan=%0d data=%h",
                     out_valid, out_chan, out_data, e.c, e.d);
        end
        step();
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < N6; i++) in_data6[i*W +: W] = 16'h6000 + 16'(i);
        in_valid6 = '1;
        sel6      = 3'd7;
        #1;
        checks++;
        if (in_ready6 !== 6'b0) begin
            errors++;
            $display("FAIL oob_ready: got %b want 000000", in_ready6);
        end
        step();
        checks++;
        if (out_valid6 !== 1'b0) begin
            errors++;
            $display("FAIL oob_no_out: valid=%b want 0", out_valid6);
        end
        sel6 = 3'd5;
        #1;
        checks++;
        if (in_ready6 !== 6'b10_0000) begin
            errors++;
            $display("FAIL oob_sel5_ready: got %b want 100000", in_ready6);
        end
        step();
        in_valid6 = '0;
        checks++;
        if ({out_valid6, out_chan6, out_data6} !== {1'b1, 3'd5, 16'h6005}) begin
            errors++;
            $display("FAIL oob_sel5_out: v=%b chan=%0d data=%h want 1/5/6005",
                     out_valid6, out_chan6, out_data6);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        rr_en     = 1'b0;
        out_ready = 1'b1;
        in_data6  = '0;
        in_valid6 = '0;
        sel6      = '0;
        #2;
        test_reset();
        test_ext_select();
        test_rr_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_mode_switch();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised N-channel, W-bit registered arbitrating multiplexer; the next generation of the CPU's 1-bit 8:1 select mux.
- Adds per-channel valid/ready handshakes, a registered output stage with backpressure, and two run-time modes:
  - external select (as today);
  - round-robin arbitration across all channels.
- Sits between producer units (register-read ports, peripheral buses) and a single shared consumer.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 8, number of input channels; legal range 2..16.
- SEL_W, 3, select/channel-index width; must satisfy 2^SEL_W >= CHANNELS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data-valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- sel  input  SEL_W  channel index used in external-select mode.
- rr_en  input  1  mode: 0 = external select, 1 = round-robin.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=CHANNELS-1, so the first round-robin search starts at channel 0.
  - in_ready is all-zero while rst is high.
- Load condition: load = !out_valid | out_ready. The output register can take a new word this cycle.
- External-select mode (rr_en=0):
  - Candidate is channel sel.
  - Grant only if sel < CHANNELS and in_valid[sel]=1.
  - sel >= CHANNELS never grants, and in_valid on other channels is ignored.
- Round-robin mode (rr_en=1):
  - Search order is last+1, last+2, ... wrapping modulo CHANNELS, ending at last.
  - Grant the first channel with in_valid=1.
  - last itself is lowest priority, so one channel cannot starve the others.
- in_ready[i] = load & grant & (granted index == i). At most one bit is set per cycle.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i data;
  - out_chan <= i;
  - out_valid <= 1;
  - last <= i. The pointer updates in both modes, so a switch to round-robin continues fairly.
- Output drain without a new transfer: if out_valid & out_ready and there is no grant, then out_valid <= 0. out_data and out_chan hold their values.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Backpressure: while out_valid=1 & out_ready=0, out_data, out_chan and out_valid are frozen and in_ready is all-zero.
- Mode or sel changes take effect in the same cycle's arbitration. A word already in the output register is unaffected.
- Producers must hold data and valid until their own ready. The block never drops or duplicates a word.
- Reset asserted mid-operation discards the held word with no output handshake.

Test Plan:
- Reset: assert rst for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0x0000, out_chan=0 throughout. After release with rr_en=1, the first grant is channel 0.
- External select: rr_en=0, sel=5, ch5=0xA5A5 valid, ch2 valid, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_data=0xA5A5, out_chan=5, out_valid=1; ch2 is never granted.
- Round-robin fairness: rr_en=1, all 8 channels valid with data 0x1000+i, out_ready=1 for 16 cycles -> out_chan sequence 0,1,...,7,0,...,7 with matching data. No channel is skipped.
- Backpressure: out_valid=1 with 0x1003, out_ready=0 for 4 cycles -> outputs frozen, in_ready=0. When out_ready=1, the next word (chan 4) is loaded in the same cycle as the drain, with no bubble.
- Sparse/wrap: rr_en=1, last=6, only ch1 and ch7 valid -> ch7 granted, then ch1. With neither valid, out_valid drops after the drain.
- Mode switch and out-of-range select: after ch3 is granted in select mode, set rr_en=1 with ch2 and ch4 valid -> ch4 is granted first. Select mode with CHANNELS=6 and sel=7 -> no grant and in_ready=0.
